// File: rtl/instr_decode_stage.sv
// -----------------------------------------------------------------------------
// instr_decode_stage
//
// Registered RV32 instruction-decode stage between fetch and execute. Each
// accepted instruction is split into its fields, classified by format and
// given a sign-extended immediate before it is stored. Storage is a main
// register, which drives the outputs, plus a skid register. Together they
// absorb one cycle of execute backpressure without a combinational
// out_ready -> in_ready path.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its data stable until it sees
// ready. in_ready comes straight from a flop and never depends on out_ready
// in the same cycle.
//
// Optional feature: define INSTR_DEC_CNT_EN to add out_count. It counts
// output transfers, wraps modulo 2^CNT_W, is cleared only by rst and is not
// affected by flush.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   flush           drop both buffered entries on the next edge
//   in_valid/ready  input handshake (in_ready is registered)
//   in_instr, in_pc raw instruction and its PC tag
//   out_valid/ready output handshake
//   out_pc          PC tag of the output entry
//   out_opcode, out_funct3, out_funct7, out_rs1, out_rs2, out_rd
//                   instruction fields sliced from the instruction
//   out_fmt         R=0 I=1 S=2 B=3 U=4 J=5 NONE=7
//   out_imm         format-correct immediate, sign-extended to XLEN
//   out_illegal     unknown opcode or instr[1:0] != 2'b11
//   out_count       accepted-output counter (INSTR_DEC_CNT_EN only)
// -----------------------------------------------------------------------------
module instr_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_fmt,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal
`ifdef INSTR_DEC_CNT_EN
    ,
    output logic [CNT_W-1:0] out_count
`endif
);

    // The U-type immediate occupies all 32 bits, so XLEN cannot be narrower.
    if (XLEN < 32 || CNT_W < 1) begin : g_param_check
        $error("instr_decode_stage: XLEN must be >= 32 and CNT_W >= 1");
    end

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    entry_t dec;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid, main_valid_d;
    logic   skid_valid, skid_valid_d;
    logic   rdy_q;
    logic   in_xfer, out_xfer;
    logic signed [31:0] imm32;

    assign in_xfer  = in_valid & rdy_q;
    assign out_xfer = main_valid & out_ready;

    // Decode the incoming instruction before it is stored. imm32 is built
    // already sign-extended to 32 bits and then widened to XLEN.
    always_comb begin
        imm32       = '0;
        dec         = '0;
        dec.pc      = in_pc;
        dec.opcode  = in_instr[6:0];
        dec.funct3  = in_instr[14:12];
        dec.funct7  = in_instr[31:25];
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
        dec.rd      = in_instr[11:7];
        dec.fmt     = FMT_NONE;
        case (in_instr[6:0])
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                imm32   = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                imm32   = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0};
            end
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
                dec.fmt = FMT_I;
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                imm32   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b0110011: begin
                dec.fmt = FMT_R;
            end
            default: begin
                dec.fmt = FMT_NONE;
            end
        endcase
        dec.imm     = XLEN'(imm32);
        dec.illegal = (dec.fmt == FMT_NONE) || (in_instr[1:0] != 2'b11);
    end

    // Storage next state. When main is empty or drains, a waiting skid entry
    // takes priority, which keeps the order. The input cannot also transfer
    // then, because in_ready is low whenever skid is occupied.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid;
        skid_valid_d = skid_valid;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid || out_xfer) begin
            if (skid_valid) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_valid <= main_valid_d;
            skid_valid <= skid_valid_d;
            rdy_q      <= !skid_valid_d;
        end
    end

`ifdef INSTR_DEC_CNT_EN
    logic [CNT_W-1:0] count_q;

    // A transfer during a flush still counts because the consumer took it.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (out_xfer) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign out_count = count_q;
`endif

    assign in_ready    = rdy_q;
    assign out_valid   = main_valid;
    assign out_pc      = main_q.pc;
    assign out_opcode  = main_q.opcode;
    assign out_funct3  = main_q.funct3;
    assign out_funct7  = main_q.funct7;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_rd      = main_q.rd;
    assign out_fmt     = main_q.fmt;
    assign out_imm     = main_q.imm;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_decode_stage
//
// Directed bench for instr_decode_stage. The DUT has no state to wait on, so
// every step is a fixed number of clock cycles. Inputs change 1 time unit
// after the rising edge, and outputs are checked at that same point, once the
// edge has settled. Expected values are hand-decoded constants. When
// INSTR_DEC_CNT_EN is defined, out_count is also checked against the tally of
// output transfers the sequence produces.
// -----------------------------------------------------------------------------
module tb_instr_decode_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;
`ifdef INSTR_DEC_CNT_EN
    logic [CNT_W-1:0] out_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [XLEN-1:0] exp_q[$];

    instr_decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_fmt     (out_fmt),
        .out_imm     (out_imm),
        .out_illegal (out_illegal)
`ifdef INSTR_DEC_CNT_EN
        ,
        .out_count   (out_count)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Checking
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_count(input string tag, input logic [63:0] exp);
`ifdef INSTR_DEC_CNT_EN
        check(tag, 64'(out_count), exp);
`else
        if (exp > 64'd0) begin
            // Counter absent in this build; nothing to compare.
        end
`endif
    endtask

    // Drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [XLEN-1:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    task automatic check_decoded(input string tag, input logic [XLEN-1:0] pc,
                                 input logic [2:0] fmt, input logic [XLEN-1:0] imm);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_pc"},    64'(out_pc),    64'(pc));
        check({tag, "_fmt"},   64'(out_fmt),   64'(fmt));
        check({tag, "_imm"},   64'(out_imm),   64'(imm));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, '0);
        step();
        step();
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_imm",       64'(out_imm),   64'd0);
        check("rst_fmt",       64'(out_fmt),   64'd0);
        check("rst_illegal",   64'(out_illegal), 64'd0);
        check_count("rst_count", 64'd0);

        // ADDI x1,x2,-1
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF10093, 32'h0000_0100);
        step();
        check_decoded("addi", 32'h100, 3'd1, 32'hFFFF_FFFF);
        check("addi_rd",  64'(out_rd),  64'd1);
        check("addi_rs1", 64'(out_rs1), 64'd2);
        check("addi_illegal", 64'(out_illegal), 64'd0);

        // Back-to-back stream, one decoded entry per cycle.
        drive(1'b1, 32'h00512423, 32'h0000_0104);   // SW x5,8(x2)
        step();
        check_decoded("sw", 32'h104, 3'd2, 32'h0000_0008);
        check("sw_rs2", 64'(out_rs2), 64'd5);
        check("sw_funct3", 64'(out_funct3), 64'd2);
        drive(1'b1, 32'hFE000EE3, 32'h0000_0108);   // BEQ x0,x0,-4
        step();
        check_decoded("beq", 32'h108, 3'd3, 32'hFFFF_FFFC);
        drive(1'b1, 32'h123451B7, 32'h0000_010C);   // LUI x3,0x12345
        step();
        check_decoded("lui", 32'h10C, 3'd4, 32'h1234_5000);
        check("lui_rd", 64'(out_rd), 64'd3);
        drive(1'b1, 32'hFF9FF06F, 32'h0000_0110);   // JAL x0,-8
        step();
        check_decoded("jal", 32'h110, 3'd5, 32'hFFFF_FFF8);
        drive(1'b1, 32'h002081B3, 32'h0000_0114);   // ADD x3,x1,x2
        step();
        check_decoded("add", 32'h114, 3'd0, 32'h0);
        check("add_rs2", 64'(out_rs2), 64'd2);
        check("add_funct7", 64'(out_funct7), 64'd0);
        drive(1'b0, 32'h0, '0);
        step();
        check("drain_valid", 64'(out_valid), 64'd0);
        check_count("stream_count", 64'd6);

        // Backpressure: three offered, two held, third stalls.
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h0000_0200); exp_q.push_back(32'h200);
        step();
        check("bp_rdy_after_1", 64'(in_ready), 64'd1);
        drive(1'b1, 32'h00200093, 32'h0000_0204); exp_q.push_back(32'h204);
        step();
        check("bp_rdy_after_2", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h00300093, 32'h0000_0208); exp_q.push_back(32'h208);
        step();
        check("bp_stall_rdy", 64'(in_ready), 64'd0);
        check("bp_stall_pc", 64'(out_pc), 64'h200);
        out_ready = 1'b1;
        check("bp_out0", 64'(out_pc), 64'(exp_q.pop_front()));
        step();
        check("bp_out1", 64'(out_pc), 64'(exp_q.pop_front()));
        check("bp_out1_valid", 64'(out_valid), 64'd1);
        step();
        check("bp_out2", 64'(out_pc), 64'(exp_q.pop_front()));
        check("bp_out2_imm", 64'(out_imm), 64'd3);
        drive(1'b0, 32'h0, '0);
        step();
        check("bp_no_dup", 64'(out_valid), 64'd0);
        check_count("bp_count", 64'd9);

        // Illegal encodings still flow through the handshake.
        drive(1'b1, 32'h00000000, 32'h0000_0300);
        step();
        check_decoded("ill0", 32'h300, 3'd7, 32'h0);
        check("ill0_illegal", 64'(out_illegal), 64'd1);
        drive(1'b1, 32'h0000007F, 32'h0000_0304);
        step();
        check("ill7f_illegal", 64'(out_illegal), 64'd1);
        check("ill7f_fmt", 64'(out_fmt), 64'd7);
        drive(1'b0, 32'h0, '0);
        step();
        check_count("ill_count", 64'd11);

        // Flush with both entries full; the output transfer still completes.
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h0000_0400);
        step();
        drive(1'b1, 32'h00200093, 32'h0000_0404);
        step();
        check("fl_full_rdy", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h00500093, 32'h0000_0408);
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, '0);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_rdy", 64'(in_ready), 64'd1);
        step();
        step();
        check("fl_never_appears", 64'(out_valid), 64'd0);
        check_count("fl_count", 64'd12);

        // Flush drops a same-cycle input transfer.
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h0000_0500);
        step();
        drive(1'b1, 32'h00700093, 32'h0000_0504);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, '0);
        check("fl2_valid", 64'(out_valid), 64'd0);
        check("fl2_rdy", 64'(in_ready), 64'd1);
        step();
        check("fl2_dropped", 64'(out_valid), 64'd0);
        check_count("fl2_count", 64'd12);

        // Reset mid-operation overrides flush and input.
        drive(1'b1, 32'hFFF10093, 32'h0000_0600);
        step();
        rst = 1'b1; flush = 1'b1;
        drive(1'b1, 32'h00100093, 32'h0000_0604);
        step();
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0, '0);
        check("rst2_valid", 64'(out_valid), 64'd0);
        check("rst2_rdy", 64'(in_ready), 64'd1);
        check("rst2_pc", 64'(out_pc), 64'd0);
        check("rst2_imm", 64'(out_imm), 64'd0);
        check_count("rst2_count", 64'd0);
        step();
        check("rst2_idle", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Registered instruction-decode pipeline stage that splits a 32-bit RV32 instruction into fields and produces format-correct, sign-extended immediates.
- Generalises plain field slicing:
  - classifies the instruction format;
  - flags illegal opcodes;
  - carries a PC tag alongside the instruction;
  - uses a valid/ready handshake with a 2-entry skid buffer.
- Sits between fetch and execute; decouples fetch from execute backpressure without a combinational ready path.

Parameters:
- XLEN, 32, width of PC tag and sign-extended immediate output.
- CNT_W, 32, width of the decoded-instruction counter (optional feature only).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drops all buffered entries.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept; driven from a register.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  PC tag.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  consumer accepts.
- out_pc  out  XLEN  PC tag of the output entry.
- out_opcode  out  7  instr[6:0].
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_rs1  out  5  instr[19:15].
- out_rs2  out  5  instr[24:20].
- out_rd  out  5  instr[11:7].
- out_fmt  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
- out_imm  out  XLEN  immediate, sign-extended to XLEN.
- out_illegal  out  1  unrecognised opcode, or instr[1:0] != 2'b11.
- out_count  out  CNT_W  accepted-output counter (only with INSTR_DEC_CNT_EN).

Behaviour:
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Latency: an accepted instruction appears at the outputs on the next cycle when the stage was empty.
- Decode happens before storage; both entries hold fully decoded data.
- Format by opcode:
  - 0110111 / 0010111 → U
  - 1101111 → J
  - 1100111, 0000011, 0010011, 0001111, 1110011 → I
  - 1100011 → B
  - 0100011 → S
  - 0110011 → R
  - anything else → NONE with illegal=1.
- Immediates:
  - I: instr[31:20] sign-extended.
  - S: {instr[31:25], instr[11:7]} sign-extended.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} sign-extended.
  - U: {instr[31:12], 12'b0} sign-extended to XLEN.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} sign-extended.
  - R and NONE: imm = 0.
- Illegal entries still flow through the handshake; out_illegal qualifies them. Fields are still sliced, fmt = 7, imm = 0.
- Storage: main register (drives the outputs) plus a skid register.
  - in_ready = !skid_valid, registered.
  - If out_valid & !out_ready and an input transfer occurs, the new entry goes to the skid register.
  - When the main register drains, the skid entry moves to main in the same edge.
  - Order is strictly preserved.
- Simultaneous input and output transfer with only main full: the new entry goes straight to main; skid stays empty.
- Full (both valid): in_ready = 0; in_valid is ignored.
- Empty: out_valid = 0; output data holds its last value and is don't-care.
- Flush:
  - Clears main_valid and skid_valid next edge; in_ready = 1 the cycle after.
  - Flush overrides a same-cycle input transfer: that instruction is dropped.
  - A same-cycle output transfer still counts as completed.
- Reset (sync):
  - out_valid = 0, in_ready = 1.
  - All out_* data = 0, out_fmt = 0, out_illegal = 0, out_count = 0.
  - Reset mid-operation discards both entries; reset overrides flush and input.

Optional Feature:
- Macro: INSTR_DEC_CNT_EN.
- Defined:
  - out_count port exists.
  - Increments by 1 on each output transfer; wraps modulo 2^CNT_W.
  - Unaffected by flush; cleared by rst.
- Undefined: out_count port and counter are absent; CNT_W is unused.

Test Plan:
- Reset then idle:
  - rst=1 for 2 cycles → out_valid=0, in_ready=1, out_imm=0, out_count=0.
- ADDI x1,x2,-1 (0xFFF10093), out_ready=1 → next cycle:
  - out_valid=1, fmt=1, rd=1, rs1=2;
  - imm=0xFFFFFFFF; illegal=0; out_pc equals in_pc.
- Back-to-back decode:
  - SW x5,8(x2) (0x00512423) → fmt=2, rs2=5, imm=0x00000008.
  - BEQ x0,x0,-4 (0xFE000EE3) → fmt=3, imm=0xFFFFFFFC.
  - LUI x3,0x12345 (0x123451B7) → fmt=4, rd=3, imm=0x12345000.
- Backpressure:
  - Hold out_ready=0, offer 3 instructions → first two accepted, in_ready falls to 0 after the second.
  - Release out_ready → outputs appear in order, one per cycle, no loss or duplication.
- Illegal:
  - 0x00000000 → out_valid=1, illegal=1, fmt=7, imm=0.
  - 0x0000007F → illegal=1.
- Flush with both entries full and in_valid=1 → next cycle out_valid=0, in_ready=1, offered instruction never appears; with INSTR_DEC_CNT_EN, out_count counts only completed output transfers.
